// File: rtl/mdio_pkg.sv
// Clause 22 MDIO frame constants and master FSM state encoding.
package mdio_pkg;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} mdio_state_t;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam int HDR_LEN  = 14;
  localparam int TA_LEN   = 2;
  localparam int DATA_LEN = 16;

endpackage

// File: rtl/mdio_master_if.sv
// Register-side request/response bundle between the MAC and the MDIO master.
interface mdio_master_if;
  import mdio_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_phy;
  logic [4:0]  req_reg;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_phy, req_reg, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_phy, req_reg, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mdio_clkgen.sv
// MDC divider: CLK_DIV clocks low then CLK_DIV high, with strobes flagging the toggling edge.
// start restarts at the beginning of a low half; the phase freezes while en is low.
module mdio_clkgen #(
  parameter int CLK_DIV = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       wrap;

  assign wrap = en && (cnt == DIV_LAST);
  assign rise = wrap && !mdc;
  assign fall = wrap && mdc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt <= '0;
        mdc <= !mdc;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO master; accept->rsp_valid = (PREAMBLE_BITS+32)*2*CLK_DIV+1 clocks, req_ready low while busy.
// Build option MDIO_MDI_SYNC_EN: mdi through a 2-flop synchroniser, sampled 2 clocks after mdc rises.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV       = 20,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  mdio_master_if.slave bus,
  output logic         mdc,
  output logic         mdo,
  output logic         mdo_en,
  input  logic         mdi
);
  localparam logic [5:0] PRE_LAST = (PREAMBLE_BITS == 0) ? 6'd0 : 6'(PREAMBLE_BITS - 1);

  mdio_state_t state;
  logic [5:0]  bit_cnt;
  logic [31:0] tx_sr;
  logic [15:0] rx_sr;
  logic        wr_q;
  logic        err_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [15:0] rsp_rdata_q;
  logic        accept;
  logic        in_frame;
  logic        mdc_rise;
  logic        mdc_fall;
  logic        sample_stb;
  logic        sample_bit;
  logic        last_bit;
  logic [31:0] frame;

  assign accept   = bus.req_valid && (state == IDLE);
  assign in_frame = (state == PRE) || (state == HDR) || (state == TA) || (state == DATA);

  // Read frames carry ones after the header so a released pad never sees a stray 0.
  assign frame = {MDIO_ST, bus.req_write ? MDIO_OP_WR : MDIO_OP_RD, bus.req_phy, bus.req_reg,
                  bus.req_write ? {2'b10, bus.req_wdata} : 18'h3ffff};

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (accept),
    .en      (in_frame),
    .mdc     (mdc),
    .rise    (mdc_rise),
    .fall    (mdc_fall)
  );

`ifdef MDIO_MDI_SYNC_EN
  logic [1:0] mdi_sync;
  logic [1:0] rise_dly;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mdi_sync <= 2'b11;
      rise_dly <= 2'b00;
    end else begin
      mdi_sync <= {mdi_sync[0], mdi};
      rise_dly <= {rise_dly[0], mdc_rise};
    end
  end

  assign sample_stb = rise_dly[1];
  assign sample_bit = mdi_sync[1];
`else
  assign sample_stb = mdc_rise;
  assign sample_bit = mdi;
`endif

  always_comb begin
    last_bit = 1'b0;
    case (state)
      PRE:     last_bit = (bit_cnt == PRE_LAST);
      HDR:     last_bit = (bit_cnt == 6'(HDR_LEN - 1));
      TA:      last_bit = (bit_cnt == 6'(TA_LEN - 1));
      DATA:    last_bit = (bit_cnt == 6'(DATA_LEN - 1));
      default: last_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      mdo         <= 1'b1;
      mdo_en      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (sample_stb && in_frame && !wr_q) begin
        if (state == TA && bit_cnt == 6'd1) err_q <= sample_bit;
        if (state == DATA) rx_sr <= {rx_sr[14:0], sample_bit};
      end
      case (state)
        IDLE: if (accept) begin
          wr_q    <= bus.req_write;
          tx_sr   <= frame;
          bit_cnt <= '0;
          err_q   <= 1'b0;
          mdo_en  <= 1'b1;
          if (PREAMBLE_BITS != 0) begin
            state <= PRE;
            mdo   <= 1'b1;
          end else begin
            state <= HDR;
            mdo   <= frame[31];
          end
        end
        DONE: state <= IDLE;
        // Bits advance only where mdc falls, so mdo is stable around every rising edge.
        default: if (mdc_fall) begin
          if (!last_bit) begin
            bit_cnt <= bit_cnt + 6'd1;
            if (state != PRE) begin
              tx_sr <= {tx_sr[30:0], 1'b0};
              mdo   <= tx_sr[30];
            end
          end else begin
            bit_cnt <= '0;
            case (state)
              PRE: begin
                state <= HDR;
                mdo   <= tx_sr[31];
              end
              HDR: begin
                state  <= TA;
                tx_sr  <= {tx_sr[30:0], 1'b0};
                mdo    <= tx_sr[30];
                mdo_en <= wr_q;
              end
              TA: begin
                state <= DATA;
                tx_sr <= {tx_sr[30:0], 1'b0};
                mdo   <= tx_sr[30];
              end
              default: begin
                state       <= DONE;
                mdo         <= 1'b1;
                mdo_en      <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= !wr_q && err_q;
                if (!wr_q) rsp_rdata_q <= rx_sr;
              end
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two configurations, frames decoded on mdc rising edges against a queue-built reference frame.
module tb_mdio_master;
  localparam int A_DIV = 4;
  localparam int A_PRE = 32;
`ifdef MDIO_MDI_SYNC_EN
  localparam int B_DIV = 3;
`else
  localparam int B_DIV = 2;
`endif
  localparam int B_PRE = 0;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_phy = '0;
  logic [4:0]  req_reg = '0;
  logic [15:0] req_wdata = '0;
  logic        phy_mdi = 1'b1;

  int total = 0;
  int bad = 0;
  logic [15:0] last_rd [2];

  mdio_master_if ia ();
  mdio_master_if ib ();
  logic mdc_a, mdo_a, en_a, mdi_a;
  logic mdc_b, mdo_b, en_b, mdi_b;

  assign ia.req_valid = req_valid && !sel;
  assign ib.req_valid = req_valid && sel;
  assign ia.req_write = req_write;
  assign ib.req_write = req_write;
  assign ia.req_phy   = req_phy;
  assign ib.req_phy   = req_phy;
  assign ia.req_reg   = req_reg;
  assign ib.req_reg   = req_reg;
  assign ia.req_wdata = req_wdata;
  assign ib.req_wdata = req_wdata;
  assign mdi_a = sel ? 1'b1 : phy_mdi;
  assign mdi_b = sel ? phy_mdi : 1'b1;

  mdio_master #(.CLK_DIV(A_DIV), .PREAMBLE_BITS(A_PRE)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ia),
    .mdc(mdc_a), .mdo(mdo_a), .mdo_en(en_a), .mdi(mdi_a)
  );
  mdio_master #(.CLK_DIV(B_DIV), .PREAMBLE_BITS(B_PRE)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ib),
    .mdc(mdc_b), .mdo(mdo_b), .mdo_en(en_b), .mdi(mdi_b)
  );

  wire        rdy_s   = sel ? ib.req_ready : ia.req_ready;
  wire        busy_s  = sel ? ib.busy      : ia.busy;
  wire        rv_s    = sel ? ib.rsp_valid : ia.rsp_valid;
  wire [15:0] rdata_s = sel ? ib.rsp_rdata : ia.rsp_rdata;
  wire        err_s   = sel ? ib.rsp_err   : ia.rsp_err;
  wire        mdc_s   = sel ? mdc_b : mdc_a;
  wire        mdo_s   = sel ? mdo_b : mdo_a;
  wire        en_s    = sel ? en_b  : en_a;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference frame: bit i of the vectors is the i-th bit on the wire.
  task automatic build_frame(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                             input logic [15:0] wd, input int pre,
                             output logic [63:0] exp_mdo, output logic [63:0] exp_en);
    logic q[$];
    logic e[$];
    for (int i = 0; i < pre; i++) begin q.push_back(1'b1); e.push_back(1'b1); end
    q.push_back(1'b0); q.push_back(1'b1);
    if (wr) begin q.push_back(1'b0); q.push_back(1'b1); end
    else    begin q.push_back(1'b1); q.push_back(1'b0); end
    for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) q.push_back(rg[i]);
    repeat (14) e.push_back(1'b1);
    if (wr) begin q.push_back(1'b1); q.push_back(1'b0); end
    else    begin q.push_back(1'b0); q.push_back(1'b0); end
    for (int i = 15; i >= 0; i--) q.push_back(wr ? wd[i] : 1'b0);
    repeat (18) e.push_back(wr);
    exp_mdo = '0;
    exp_en  = '0;
    for (int i = 0; i < q.size(); i++) begin exp_mdo[i] = q[i]; exp_en[i] = e[i]; end
  endtask

  // What the PHY (or the pull-up) puts on the pad during wire bit idx.
  function automatic logic resp_bit(input logic wr, input int idx, input int pre,
                                    input logic present, input logic [15:0] pdata);
    if (wr || !present) return 1'b1;
    if (idx == pre + 15) return 1'b0;
    if (idx >= pre + 16 && idx < pre + 32) return pdata[15 - (idx - pre - 16)];
    return 1'b1;
  endfunction

  task automatic run_frame(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, input logic present, input logic [15:0] pdata,
                           input logic hold, output int waitc);
    int pre, div, n_bits, exp_lat, lat, nrise, si;
    logic [63:0] exp_mdo, exp_en, got_mdo, got_en;
    logic prev;
    pre = sel ? B_PRE : A_PRE;
    div = sel ? B_DIV : A_DIV;
    si = sel ? 1 : 0;
    n_bits = pre + 32;
    exp_lat = n_bits * 2 * div + 1;
    build_frame(wr, phy, rg, wd, pre, exp_mdo, exp_en);
    req_write = wr; req_phy = phy; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
    waitc = 0;
    while (rdy_s !== 1'b1 && waitc < 20) begin @(negedge clock); waitc++; end
    chk("accept_ready", rdy_s, 1'b1);
    got_mdo = '0; got_en = '0; nrise = 0; lat = 0; prev = mdc_s;
    phy_mdi = resp_bit(wr, 0, pre, present, pdata);
    while (lat < exp_lat + 40) begin
      @(negedge clock);
      lat++;
      if (!hold) req_valid = 1'b0;
      if (mdc_s === 1'b1 && prev === 1'b0) begin
        if (nrise < 64) begin got_mdo[nrise] = mdo_s; got_en[nrise] = en_s; end
        nrise++;
        phy_mdi = resp_bit(wr, nrise, pre, present, pdata);
      end
      prev = mdc_s;
      if (rv_s === 1'b1) break;
    end
    chk("latency", lat, exp_lat);
    chk("bit_count", nrise, n_bits);
    chk("mdo_en_bits", got_en, exp_en);
    chk("mdo_bits", got_mdo & exp_en, exp_mdo & exp_en);
    chk("done_mdc", mdc_s, 1'b0);
    chk("done_mdo", mdo_s, 1'b1);
    chk("done_mdo_en", en_s, 1'b0);
    chk("done_busy", busy_s, 1'b1);
    if (!wr) begin
      last_rd[si] = present ? pdata : 16'hFFFF;
      chk("rsp_err_rd", err_s, !present);
    end else begin
      chk("rsp_err_wr", err_s, 1'b0);
    end
    chk("rsp_rdata", rdata_s, last_rd[si]);
    phy_mdi = 1'b1;
    @(negedge clock);
    chk("idle_ready", rdy_s, 1'b1);
    chk("idle_mdc", mdc_s, 1'b0);
    chk("idle_rsp_valid", rv_s, 1'b0);
    chk("idle_busy", busy_s, 1'b0);
  endtask

  initial begin
    int w, cnt;
    logic [15:0] d;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clock);
    chk("rst_mdc", {mdc_a, mdc_b}, 2'b00);
    chk("rst_mdo", {mdo_a, mdo_b}, 2'b11);
    chk("rst_mdo_en", {en_a, en_b}, 2'b00);
    chk("rst_ready", {ia.req_ready, ib.req_ready}, 2'b11);
    chk("rst_busy", {ia.busy, ib.busy}, 2'b00);
    chk("rst_rsp_valid", {ia.rsp_valid, ib.rsp_valid}, 2'b00);
    chk("rst_rdata", {ia.rsp_rdata, ib.rsp_rdata}, 32'h0);
    chk("rst_err", {ia.rsp_err, ib.rsp_err}, 2'b00);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_frame(1'b1, 5'h01, 5'h00, 16'h8000, 1'b1, 16'h0, 1'b0, w);
    run_frame(1'b0, 5'h03, 5'h02, 16'h0, 1'b1, 16'h0141, 1'b0, w);
    run_frame(1'b0, 5'h03, 5'h02, 16'h0, 1'b0, 16'h0, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      run_frame(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom), d, 1'b0, w);
    end

    sel = 1'b1;
    @(negedge clock);
    run_frame(1'b1, 5'h01, 5'h00, 16'h8000, 1'b1, 16'h0, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      run_frame(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, d, 1'b0, w);
    end

    sel = 1'b0;
    @(negedge clock);
    d = 16'($urandom);
    run_frame(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, 16'h0, 1'b1, w);
    run_frame(1'b0, 5'($urandom), 5'($urandom), 16'h0, 1'b1, d, 1'b0, w);
    chk("b2b_accept_wait", w, 0);

    // Reset in the middle of the data field of a write.
    req_write = 1'b1; req_phy = 5'h07; req_reg = 5'h11; req_wdata = 16'hFFFF; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (444) @(negedge clock);
    chk("pre_reset_mdo_en", en_s, 1'b1);
    chk("pre_reset_busy", busy_s, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("reset_mdo_en", en_s, 1'b0);
    chk("reset_mdc", mdc_s, 1'b0);
    chk("reset_mdo", mdo_s, 1'b1);
    chk("reset_ready", rdy_s, 1'b1);
    chk("reset_busy", busy_s, 1'b0);
    chk("reset_rdata", rdata_s, 16'h0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    repeat (600) begin
      @(negedge clock);
      if (rv_s === 1'b1) cnt++;
    end
    chk("no_rsp_after_reset", cnt, 0);
    d = 16'($urandom);
    run_frame(1'b0, 5'h03, 5'h02, 16'h0, 1'b1, d, 1'b0, w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
